// File: rtl/lsu.sv
// Load/store unit: takes one RV32I memory instruction at a time from decode.
// It checks the width code and the alignment, runs a single request/acknowledge
// bus transaction, and returns a formatted load result or an error pulse.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_data,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        err,
  output logic [1:0]  err_cause
);

  // The bus aborts on the last BUS cycle of the budget that has no acknowledge.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP, ERR} state_t;
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ILLEGAL  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } cause_t;

  state_t      state, next_state;
  logic        accept, illegal, misaligned, ack_hit, timed_out;
  logic [7:0]  tmo_cnt;
  logic [2:0]  op_funct3;   // width code of the transaction in flight
  logic [1:0]  op_off;      // byte offset of the transaction in flight

  // Byte enables for a store: the lane mask is shifted to the byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across every lane so the memory only needs byte enables.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Pick the addressed byte/halfword out of the bus word and extend it to 32 bits.
  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*off +: 8];
    h = rdata[16*off[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return rdata;
    endcase
  endfunction

  // Request qualification and bus-phase events.
  always_comb begin
    accept     = req_valid & req_ready;
    illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) && alu_data[0]) ||
                 ((funct3[1:0] == 2'b10) && (alu_data[1:0] != 2'b00));
    ack_hit    = (state == BUS) && mem_ack;
    timed_out  = (state == BUS) && !mem_ack && (tmo_cnt == TMO_LAST);
  end

  // Next-state logic; an acknowledge on the final budget cycle still completes normally.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = (illegal || misaligned) ? ERR : BUS;
      BUS:     if (ack_hit) next_state = RESP;
               else if (timed_out) next_state = ERR;
      RESP:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Registered outputs, latched command and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cause <= CAUSE_NONE;
      ld_data   <= '0;
      tmo_cnt   <= '0;
      op_funct3 <= '0;
      op_off    <= '0;
    end else begin
      req_ready <= (next_state == IDLE);
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              err       <= 1'b1;
              err_cause <= CAUSE_ILLEGAL;
            end else if (misaligned) begin
              err       <= 1'b1;
              err_cause <= CAUSE_MISALIGN;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {alu_data[31:2], 2'b00};
              mem_be    <= is_store ? store_be(funct3, alu_data[1:0]) : 4'b1111;
              mem_wdata <= store_wdata(funct3, st_data);
              op_funct3 <= funct3;
              op_off    <= alu_data[1:0];
              tmo_cnt   <= '0;
            end
          end
        end
        BUS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) ld_data <= load_format(op_funct3, op_off, mem_rdata);
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req   <= 1'b0;
            err       <= 1'b1;
            err_cause <= CAUSE_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the stimulus process queues expected bus activity
// and expected responses; a bus responder and a response monitor pop and compare.
module tb_lsu;

  localparam int TIMEOUT = 4;

  logic        clk, rst_n;
  logic        req_valid, req_ready, is_store;
  logic [2:0]  funct3;
  logic [31:0] alu_data, st_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, ld_data;
  logic [3:0]  mem_be;
  logic        done, err;
  logic [1:0]  err_cause;

  lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .alu_data(alu_data), .st_data(st_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .done(done),
    .ld_data(ld_data), .err(err), .err_cause(err_cause)
  );

  typedef struct {
    bit          is_err;
    logic [1:0]  cause;
    logic [31:0] ld;
    int          acc;
    int          lat;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          delay;
    int          acc;
    bit          aborted;
  } bus_t;

  resp_t       resp_q[$];
  bus_t        bus_q[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc_cnt = 0;
  logic [31:0] last_ld = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one instruction and queue what the reference model says must happen.
  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [31:0] rd, input int delay,
                       input bit abort);
    int     n = 0;
    int     sz, off, acc;
    bit     ill, mis;
    longint v;
    resp_t  r;
    bus_t   b;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) check("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1;
    is_store  = st;
    funct3    = f3;
    alu_data  = addr;
    st_data   = sd;
    @(posedge clk);
    #1;
    acc       = cyc_cnt;
    req_valid = 1'b0;
    is_store  = 1'($urandom);
    funct3    = 3'($urandom);
    alu_data  = $urandom;
    st_data   = $urandom;

    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3[2]);
    sz  = 1 << f3[1:0];
    off = int'(addr % 4);
    mis = !ill && ((addr % sz) != 0);
    r.acc = acc;
    r.ld  = last_ld;
    if (ill || mis) begin
      r.is_err = 1'b1;
      r.cause  = ill ? 2'b10 : 2'b01;
      r.lat    = 0;
      resp_q.push_back(r);
      return;
    end
    b.we      = st;
    b.addr    = addr & 32'hFFFF_FFFC;
    b.be      = st ? 4'(((1 << sz) - 1) << off) : 4'hF;
    b.wdata   = (sz == 1) ? sd[7:0] * 32'h0101_0101 :
                (sz == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    b.rdata   = rd;
    b.delay   = delay;
    b.acc     = acc;
    b.aborted = abort;
    bus_q.push_back(b);
    if (abort) return;
    if (delay >= TIMEOUT) begin
      r.is_err = 1'b1;
      r.cause  = 2'b11;
      r.lat    = TIMEOUT;
    end else begin
      if (!st) begin
        v = (longint'(rd) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
        if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        last_ld = 32'(v);
      end
      r.is_err = 1'b0;
      r.cause  = 2'b00;
      r.ld     = last_ld;
      r.lat    = delay + 1;
    end
    resp_q.push_back(r);
  endtask

  // Bus responder: checks the request against the queue and acknowledges after the chosen delay.
  initial begin
    bus_t b;
    int   cyc;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (bus_q.size() == 0) begin
          check("unexpected_mem_req", mem_req, 1'b0);
        end else begin
          b   = bus_q.pop_front();
          cyc = 0;
          check("mem_req_rise_cycle", cyc_cnt, b.acc);
          while (mem_req === 1'b1 && cyc < 300) begin
            check("mem_addr", mem_addr, b.addr);
            check("mem_we", mem_we, b.we);
            check("mem_be", mem_be, b.be);
            if (b.we) check("mem_wdata", mem_wdata, b.wdata);
            if (cyc == b.delay) begin
              mem_ack   = 1'b1;
              mem_rdata = b.rdata;
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            cyc++;
          end
          if (!b.aborted)
            check("mem_req_cycles", cyc, (b.delay < TIMEOUT) ? b.delay + 1 : TIMEOUT);
        end
      end
    end
  end

  // Response monitor: every done/err pulse must match the head of the response queue.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) begin
        if (resp_q.size() == 0) begin
          check("unexpected_done", done, 1'b0);
          check("unexpected_err", err, 1'b0);
        end else begin
          r = resp_q.pop_front();
          check("err_flag", err, r.is_err);
          check("done_flag", done, !r.is_err);
          check("ld_data", ld_data, r.ld);
          if (r.is_err) check("err_cause", err_cause, r.cause);
          check("latency", cyc_cnt - r.acc, r.lat);
        end
      end
    end
  end

  // Stimulus: reset, directed cases, random traffic, reset during a bus cycle.
  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    is_store  = 1'b0;
    funct3    = '0;
    alu_data  = '0;
    st_data   = '0;
    #3;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", mem_be, 4'h0);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_err_cause", err_cause, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("req_ready_after_reset", req_ready, 1'b1);

    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 2, 1'b0);   // LB sign-extended
    issue(1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'h0, 0, 1'b0);   // SH, same-cycle ack
    issue(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b0);           // LW misaligned
    issue(1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 0, 1'b0);           // illegal funct3
    issue(1'b0, 3'b011, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b0);           // illegal beats misaligned
    issue(1'b1, 3'b100, 32'h0000_3000, 32'h0, 32'h0, 0, 1'b0);           // store with unsigned code
    issue(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h1111_2222, 99, 1'b0);  // never acked: timeout
    issue(1'b0, 3'b101, 32'h0000_5002, 32'h0, 32'hBEEF_0001, TIMEOUT - 1, 1'b0); // ack on last cycle
    issue(1'b1, 3'b000, 32'h0000_6001, 32'hA5A5_A5C3, 32'h0, 1, 1'b0);   // SB lane 1
    issue(1'b0, 3'b001, 32'h0000_7002, 32'h0, 32'h8001_7FFF, 0, 1'b0);   // LH upper half, negative

    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset while the bus is waiting: the request must drop at once and nothing may complete.
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 99, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_err", err, 1'b0);
    check("abort_ld_data", ld_data, 32'h0);
    last_ld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("req_ready_after_abort", req_ready, 1'b1);
    issue(1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h0000_F00F, 1, 1'b0);   // LHU after abort

    n = 0;
    while ((resp_q.size() != 0 || bus_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_resp_q", resp_q.size(), 0);
    check("drain_bus_q", bus_q.size(), 0);
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
